// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants used by the fetch stage and later stages.
package mips_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    // Instruction addresses are always word-aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and bubble-injection controls.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_WORD
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    localparam if_id_t BUBBLE = '{NOP, {XLEN{1'b0}}, 1'b0};

    // Flush outranks hold so a redirect always discards the wrong-path word.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (flush) begin
            q <= BUBBLE;
        end else if (hold) begin
            q <= q;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, range check and IF/ID capture.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     IMEM_BYTES = 24,
    parameter logic [XLEN-1:0] NOP_WORD   = mips_pkg::NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc4,
    output logic            ifid_valid,
    output logic            addr_fault
);

    localparam logic [XLEN-1:0] PC_INIT    = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);

    logic [XLEN-1:0] pc_r;
    logic            addr_fault_r;
    logic [XLEN-1:0] pc4_s;
    logic            out_of_range_s;
    logic            flush_s;
    if_id_t          capture_s;
    if_id_t          ifid_q_s;

    // Sequential fall-through address, range check and IF/ID capture word.
    always_comb begin
        pc4_s           = pc_r + 32'd4;
        out_of_range_s  = (pc_r >= IMEM_LIMIT);
        flush_s         = branch_taken | (~stall & out_of_range_s);
        capture_s.instr = instr_in;
        capture_s.pc4   = pc4_s;
        capture_s.valid = 1'b1;
    end

    // PC register: reset, then redirect, then stall hold, else advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= PC_INIT;
        end else if (branch_taken) begin
            pc_r <= word_align(branch_target);
        end else if (stall) begin
            pc_r <= pc_r;
        end else begin
            pc_r <= pc4_s;
        end
    end

    // Sticky fault: only a real (unstalled, unredirected) capture out of range sets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_fault_r <= 1'b0;
        end else if (!branch_taken && !stall && out_of_range_s) begin
            addr_fault_r <= 1'b1;
        end else begin
            addr_fault_r <= addr_fault_r;
        end
    end

    if_id_reg #(
        .NOP (NOP_WORD)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (stall),
        .flush (flush_s),
        .d     (capture_s),
        .q     (ifid_q_s)
    );

    assign pc_out     = pc_r;
    assign addr_fault = addr_fault_r;
    assign ifid_instr = ifid_q_s.instr;
    assign ifid_pc4   = ifid_q_s.pc4;
    assign ifid_valid = ifid_q_s.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a small combinational ROM model.
module tb_fetch_stage;

    logic        clk;
    logic        rst, stall, branch_taken;
    logic [31:0] branch_target, instr_in;
    logic [31:0] pc_out, ifid_instr, ifid_pc4;
    logic        ifid_valid, addr_fault;

    logic        rst2;
    logic [31:0] instr_in2, pc_out2, ifid_instr2, ifid_pc42;
    logic        ifid_valid2, addr_fault2;

    int n_checks;
    int n_errors;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .addr_fault    (addr_fault)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk           (clk),
        .rst           (rst2),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (32'h0000_0000),
        .instr_in      (instr_in2),
        .pc_out        (pc_out2),
        .ifid_instr    (ifid_instr2),
        .ifid_pc4      (ifid_pc42),
        .ifid_valid    (ifid_valid2),
        .addr_fault    (addr_fault2)
    );

    // Populated words for addresses 0..20; anything else returns a marker word.
    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'd0:   return 32'h8C02_000E;
            32'd4:   return 32'h4129_0002;
            32'd8:   return 32'h0000_0000;
            32'd12:  return 32'h0062_3020;
            32'd16:  return 32'h2042_0001;
            32'd20:  return 32'hAC02_0018;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign instr_in  = rom(pc_out);
    assign instr_in2 = rom(pc_out2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                                input logic [31:0] pc4, input logic vld, input logic flt);
        check({tag, ".pc"},    pc_out,            pc);
        check({tag, ".instr"}, ifid_instr,        ins);
        check({tag, ".pc4"},   ifid_pc4,          pc4);
        check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, vld});
        check({tag, ".fault"}, {31'd0, addr_fault}, {31'd0, flt});
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        rst2          = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0000_0000;

        step();
        expect_state("reset", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0);
        check("wrap.reset_pc", pc_out2, 32'hFFFF_FFFC);
        rst  = 1'b0;
        rst2 = 1'b0;

        // Free-running fetch
        step();
        expect_state("run1", 32'd4, 32'h8C02_000E, 32'd4, 1'b1, 1'b0);
        check("wrap.pc", pc_out2, 32'd0);
        check("wrap.bubble", {31'd0, ifid_valid2}, 32'd0);
        check("wrap.fault", {31'd0, addr_fault2}, 32'd1);
        step();
        expect_state("run2", 32'd8, 32'h4129_0002, 32'd8, 1'b1, 1'b0);
        check("wrap.instr0", ifid_instr2, 32'h8C02_000E);
        check("wrap.valid0", {31'd0, ifid_valid2}, 32'd1);

        // Stall holds PC and IF/ID
        stall = 1'b1;
        step();
        expect_state("stall1", 32'd8, 32'h4129_0002, 32'd8, 1'b1, 1'b0);
        step();
        expect_state("stall2", 32'd8, 32'h4129_0002, 32'd8, 1'b1, 1'b0);
        stall = 1'b0;
        step();
        expect_state("release", 32'd12, 32'h0000_0000, 32'd12, 1'b1, 1'b0);

        // Redirect to 4, then misaligned redirect from 4 to 0xE -> 12
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0004;
        step();
        expect_state("br_a", 32'd4, 32'h0, 32'd0, 1'b0, 1'b0);
        branch_target = 32'h0000_000E;
        step();
        expect_state("br_b", 32'd12, 32'h0, 32'd0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        step();
        expect_state("br_after", 32'd16, 32'h0062_3020, 32'd16, 1'b1, 1'b0);

        // Branch together with stall: stall ignored, bubble captured
        branch_taken  = 1'b1;
        stall         = 1'b1;
        branch_target = 32'h0000_0010;
        step();
        expect_state("br_stall", 32'd16, 32'h0, 32'd0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        stall        = 1'b0;
        step();
        expect_state("run16", 32'd20, 32'h2042_0001, 32'd20, 1'b1, 1'b0);
        step();
        expect_state("run20", 32'd24, 32'hAC02_0018, 32'd24, 1'b1, 1'b0);

        // Stalled at an out-of-range address does not fault
        stall = 1'b1;
        step();
        expect_state("oor_stall", 32'd24, 32'hAC02_0018, 32'd24, 1'b1, 1'b0);
        stall = 1'b0;
        step();
        expect_state("oor_fetch", 32'd28, 32'h0, 32'd0, 1'b0, 1'b1);

        // Redirect back into range; fault stays sticky
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0000;
        step();
        expect_state("recover_br", 32'd0, 32'h0, 32'd0, 1'b0, 1'b1);
        branch_taken = 1'b0;
        step();
        expect_state("recover_run", 32'd4, 32'h8C02_000E, 32'd4, 1'b1, 1'b1);

        // Reset overrides stall and branch
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0014;
        rst           = 1'b1;
        step();
        expect_state("mid_rst", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0);
        rst          = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        step();
        expect_state("post_rst", 32'd4, 32'h8C02_000E, 32'd4, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the MIPS pipeline.
- Owns the program counter and drives the byte address into the combinational instruction ROM (inst_mem).
- Captures the returned big-endian 32-bit word into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch redirects from ID (with a one-slot flush) and out-of-range fetch detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
IMEM_BYTES, 24, byte size of the populated instruction ROM; fetches at or above this address are out of range.
NOP_WORD, 32'h0000_0000, word injected into IF/ID on bubble or fault.

Ports:
clk  input  1  single pipeline clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  hazard-unit load-use stall; hold PC and IF/ID.
branch_taken  input  1  ID-stage branch/jump resolved taken this cycle.
branch_target  input  32  redirect byte address from ID.
instr_in  input  32  word returned combinationally by inst_mem for pc_out.
pc_out  output  32  current fetch byte address to inst_mem.
ifid_instr  output  32  IF/ID registered instruction.
ifid_pc4  output  32  IF/ID registered pc_out+4.
ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
addr_fault  output  1  sticky; an out-of-range fetch occurred.

Behaviour:
- Clock and reset:
  - One clock, clk. rst is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - pc_out = RESET_PC (low 2 bits forced 0).
  - ifid_instr = NOP_WORD, ifid_pc4 = 0, ifid_valid = 0, addr_fault = 0.
- Latency:
  - pc_out is registered.
  - instr_in is valid combinationally in the same cycle.
  - The word fetched at pc_out in cycle N appears on ifid_instr in cycle N+1.
- Priority per edge: rst > branch_taken > stall > normal.
- normal (no rst, no branch, no stall):
  - pc_out <= pc_out + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - IF/ID captures the current fetch: instr_in, pc_out+4, valid=1.
- stall=1 (no branch):
  - pc_out, ifid_instr, ifid_pc4 and ifid_valid all hold.
  - The same address is re-presented to the ROM.
- branch_taken=1:
  - pc_out <= {branch_target[31:2], 2'b00}; misaligned targets are silently aligned.
  - IF/ID <= bubble (NOP_WORD, ifid_pc4=0, valid=0): the wrong-path word fetched this cycle is discarded.
  - Redirect wins over a simultaneous stall; stall is ignored that cycle.
  - Back-to-back branch_taken cycles each redirect, and each inserts a bubble.
- Out-of-range fetch (pc_out >= IMEM_BYTES) on a normal capture:
  - IF/ID <= bubble (NOP_WORD, valid=0).
  - addr_fault <= 1 and stays set until rst.
  - PC still advances and stays overwritable by branch_taken, so a redirect back into range resumes normal fetch.
  - A stalled or redirected cycle at an out-of-range address does not set the fault.
- Reset mid-operation:
  - Overrides stall and branch that cycle.
  - Fetch restarts at RESET_PC on the following cycle.
- Widths and arithmetic:
  - All PC arithmetic is 32-bit unsigned; the carry out of +4 is dropped.
  - The comparison against IMEM_BYTES is unsigned.
- No combinational path from stall or branch_taken to pc_out.

Decomposition:
- Shared package mips_pkg:
  - XLEN=32, NOP_WORD, RESET_PC default.
  - Typedef if_id_t {instr[31:0], pc4[31:0], valid}, reused by the ID stage.
- One natural sub-module, if_id_reg: the IF/ID register with hold (stall) and flush (bubble) controls, reused pattern for later pipeline registers.
- PC register, next-PC mux and range check stay in fetch_stage.

Test Plan:
1. Reset then 4 free-running cycles with the ROM model loaded:
   - pc_out goes 0,4,8,12.
   - ifid_instr = 32'h8C02000E (lw $2,14($0)), then 32'h41290002, then 0, with valid=1 each.
2. stall=1 for 2 cycles at pc_out=8:
   - pc_out stays 8; IF/ID stays {32'h41290002, pc4=8, valid=1}.
   - Release: next capture is word@8 with pc4=12.
3. branch_taken=1, branch_target=32'h0000000E at pc_out=4:
   - Next cycle pc_out=12 and ifid_valid=0, ifid_instr=0.
   - Following cycle IF/ID = {32'h00623020, 16, 1}.
4. branch_taken=1 and stall=1 together, target=16:
   - pc_out=16 and a bubble is captured; stall is ignored.
5. Run past IMEM_BYTES=24 (pc_out=24):
   - IF/ID gets a bubble and addr_fault=1.
   - branch to 0: fetch resumes with valid=1 while addr_fault stays 1 until rst.
6. Force pc_out=32'hFFFFFFFC (RESET_PC override build):
   - Next pc_out=0.
   - rst asserted mid-stall returns all outputs to reset values in one edge.
